// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: writeback control bit positions,
// default datapath widths and the MEM/WB payload layout.
package mips32_pkg;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;

  localparam int S_WB_DEF      = 2;
  localparam int SIZE_DATA_DEF = 32;
  localparam int SIZE_ADDR_DEF = 5;

  // Field order matches the packing used inside mem_wb_stage.
  typedef struct packed {
    logic [S_WB_DEF-1:0]      wb;
    logic [SIZE_DATA_DEF-1:0] rd_data;
    logic [SIZE_DATA_DEF-1:0] alu;
    logic [SIZE_ADDR_DEF-1:0] dest;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_skid.sv
// Generic two-entry valid/ready skid buffer with a registered in_ready and a
// synchronous clear that drops every held entry and the input of that cycle.
module mem_wb_skid #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);

  logic         main_valid, main_valid_nxt;
  logic         skid_valid, skid_valid_nxt;
  logic [P-1:0] main_data, main_data_nxt;
  logic [P-1:0] skid_data, skid_data_nxt;
  logic         ready_q;
  logic         accept;

  assign accept    = in_valid & ready_q & ~clear;
  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (clear) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid || out_ready) begin
      // Main is free this cycle; older skid content always goes first.
      if (skid_valid) begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = skid_data;
        skid_valid_nxt = accept;
        if (accept) skid_data_nxt = in_data;
      end else begin
        main_valid_nxt = accept;
        if (accept) main_data_nxt = in_data;
        skid_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      main_data  <= main_data_nxt;
      skid_data  <= skid_data_nxt;
      ready_q    <= ~skid_valid_nxt;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS32 MEM/WB stage: skid-buffered handshake, flush, writeback mux and
// forwarding taps. Define MEM_WB_PERF_EN to add bubble/stall counters.
module mem_wb_stage
  import mips32_pkg::*;
#(
  parameter int S_WB      = S_WB_DEF,
  parameter int SIZE_DATA = SIZE_DATA_DEF,
  parameter int SIZE_ADDR = SIZE_ADDR_DEF,
  parameter int PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [S_WB-1:0]      in_wb,
  input  logic [SIZE_DATA-1:0] in_rd_data,
  input  logic [SIZE_DATA-1:0] in_alu,
  input  logic [SIZE_ADDR-1:0] in_dest,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [S_WB-1:0]      out_wb,
  output logic                 out_reg_write,
  output logic [SIZE_DATA-1:0] out_wb_data,
  output logic [SIZE_ADDR-1:0] out_dest,
  output logic                 fwd_valid,
  output logic [SIZE_ADDR-1:0] fwd_dest,
  output logic [SIZE_DATA-1:0] fwd_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_bubble,
  output logic [PERF_W-1:0]    perf_stall
`endif
);

  localparam int P = S_WB + 2 * SIZE_DATA + SIZE_ADDR;

  logic [P-1:0]         in_pay;
  logic [P-1:0]         out_pay;
  logic [SIZE_DATA-1:0] held_rd_data;
  logic [SIZE_DATA-1:0] held_alu;

  assign in_pay = {in_wb, in_rd_data, in_alu, in_dest};

  mem_wb_skid #(.P(P)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  assign {out_wb, held_rd_data, held_alu, out_dest} = out_pay;

  assign out_reg_write = out_valid & out_wb[WB_REGWRITE_BIT];
  assign out_wb_data   = out_wb[WB_MEMTOREG_BIT] ? held_rd_data : held_alu;

  // Writes to $zero are never forwarded.
  assign fwd_valid = out_reg_write & (out_dest != '0);
  assign fwd_dest  = out_dest;
  assign fwd_data  = out_wb_data;

`ifdef MEM_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble <= '0;
      perf_stall  <= '0;
    end else begin
      if (!out_valid && (perf_bubble != '1)) perf_bubble <= perf_bubble + 1'b1;
      if (out_valid && !out_ready && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; counter checks are compiled
// only when MEM_WB_PERF_EN is defined.
module tb_mem_wb_stage;
  import mips32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb;
  logic [31:0] in_rd_data;
  logic [31:0] in_alu;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wb;
  logic        out_reg_write;
  logic [31:0] out_wb_data;
  logic [4:0]  out_dest;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
`ifdef MEM_WB_PERF_EN
  logic [3:0]  perf_bubble;
  logic [3:0]  perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.S_WB(2), .SIZE_DATA(32), .SIZE_ADDR(5), .PERF_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wb         (in_wb),
    .in_rd_data    (in_rd_data),
    .in_alu        (in_alu),
    .in_dest       (in_dest),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_wb        (out_wb),
    .out_reg_write (out_reg_write),
    .out_wb_data   (out_wb_data),
    .out_dest      (out_dest),
    .fwd_valid     (fwd_valid),
    .fwd_dest      (fwd_dest),
    .fwd_data      (fwd_data)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_bubble   (perf_bubble),
    .perf_stall    (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] dest);
    in_valid   = v;
    in_wb      = wb;
    in_rd_data = rd;
    in_alu     = alu;
    in_dest    = dest;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Stream one entry, then reset asynchronously mid-cycle
    drive(1'b1, 2'b01, 32'h0, 32'h55, 5'd2);
    tick();
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_data", 64'(out_wb_data), 64'h0);
    chk("rst_reg_write", 64'(out_reg_write), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    rst_n = 1'b1;

    // Back-to-back stream, one cycle latency
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 32'h0, 32'h10 + 32'(i), 5'd3);
      tick();
      chk("stream_data", 64'(out_wb_data), 64'h10 + 64'(i));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ready", 64'(in_ready), 64'd1);
    end

    // MemToReg selects read data
    drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd7);
    tick();
    chk("memtoreg_data", 64'(out_wb_data), 64'hDEADBEEF);
    chk("memtoreg_rw", 64'(out_reg_write), 64'd1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_rw", 64'(out_reg_write), 64'd0);

    // Back-pressure: A in main, B in skid, C stalled
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'hA0, 5'd1);
    tick();
    chk("bp_a_main", 64'(out_wb_data), 64'hA0);
    chk("bp_ready_a", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b01, 32'h0, 32'hB0, 5'd1);
    tick();
    chk("bp_ready_b", 64'(in_ready), 64'd0);
    chk("bp_a_held", 64'(out_wb_data), 64'hA0);
    drive(1'b1, 2'b01, 32'h0, 32'hC0, 5'd1);
    tick();
    chk("bp_c_stall", 64'(out_wb_data), 64'hA0);
    chk("bp_ready_c", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", 64'(out_wb_data), 64'hB0);
    chk("bp_ready_rel", 64'(in_ready), 64'd1);
    tick();
    chk("bp_c_out", 64'(out_wb_data), 64'hC0);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with main and skid full and D offered
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'hA2, 5'd1);
    tick();
    drive(1'b1, 2'b01, 32'h0, 32'hB2, 5'd1);
    tick();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 2'b01, 32'h0, 32'hD0, 5'd1);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    // Flush while in_ready=1: the offered D is still dropped
    flush = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'hE0, 5'd1);
    tick();
    chk("fl2_e_main", 64'(out_wb_data), 64'hE0);
    flush = 1'b1;
    drive(1'b1, 2'b01, 32'h0, 32'hD1, 5'd1);
    tick();
    chk("fl2_valid", 64'(out_valid), 64'd0);
    chk("fl2_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("fl2_no_d", 64'(out_valid), 64'd0);

    // Forwarding suppression for $zero
    drive(1'b1, 2'b01, 32'h0, 32'h77, 5'd0);
    tick();
    chk("fwd0_rw", 64'(out_reg_write), 64'd1);
    chk("fwd0_valid", 64'(fwd_valid), 64'd0);
    drive(1'b1, 2'b01, 32'h0, 32'h77, 5'd5);
    tick();
    chk("fwd5_valid", 64'(fwd_valid), 64'd1);
    chk("fwd5_dest", 64'(fwd_dest), 64'd5);
    chk("fwd5_data", 64'(fwd_data), 64'h77);
    drive(1'b1, 2'b00, 32'h0, 32'h78, 5'd5);
    tick();
    chk("norw_rw", 64'(out_reg_write), 64'd0);
    chk("norw_fwd", 64'(fwd_valid), 64'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();

`ifdef MEM_WB_PERF_EN
    rst_n = 1'b0;
    #1;
    chk("perf_rst_bubble", 64'(perf_bubble), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("perf_bubble_sat", 64'(perf_bubble), 64'd15);
    chk("perf_stall_idle", 64'(perf_stall), 64'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'h99, 5'd4);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("perf_stall_3", 64'(perf_stall), 64'd3);
    chk("perf_bubble_1", 64'(perf_bubble), 64'd1);
    out_ready = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
